// File: rtl/mem_stage_bytes_if.sv
// M-side request and W-side result bundle for the RV32I memory-access stage.
// The master drives the M-stage fields and stall/flush; the slave returns the W-stage fields.
interface mem_stage_bytes_if;
    logic        stallW;
    logic        flushW;
    logic        reg_wrM;
    logic [1:0]  result_srcM;
    logic        mem_wrM;
    logic [2:0]  funct3M;
    logic [31:0] ALU_resultM;
    logic [31:0] wr_dataM;
    logic [31:0] PCp4M;
    logic [4:0]  rdM;

    logic        reg_wrW;
    logic [1:0]  result_srcW;
    logic [31:0] ALU_resultW;
    logic [31:0] rd_dataW;
    logic [31:0] PCp4W;
    logic [4:0]  rdW;
    logic        misalignW;

    modport master (
        output stallW, flushW, reg_wrM, result_srcM, mem_wrM, funct3M,
               ALU_resultM, wr_dataM, PCp4M, rdM,
        input  reg_wrW, result_srcW, ALU_resultW, rd_dataW, PCp4W, rdW, misalignW
    );

    modport slave (
        input  stallW, flushW, reg_wrM, result_srcM, mem_wrM, funct3M,
               ALU_resultM, wr_dataM, PCp4M, rdM,
        output reg_wrW, result_srcW, ALU_resultW, rd_dataW, PCp4W, rdW, misalignW
    );
endinterface

// File: rtl/mem_stage_bytes.sv
// RV32I memory stage with byte-enable data memory and the MEM/WB register.
// Optional macro MISALIGN_EXC_EN: flag and suppress misaligned half/word accesses.
module mem_stage_bytes #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC4  = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_bytes_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            off;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  misal;
    logic                  we;

    logic        reg_wr_q;
    logic [1:0]  result_src_q;
    logic [31:0] alu_q;
    logic [31:0] pc4_q;
    logic [4:0]  rd_q;
    logic        misalign_q;
    logic [31:0] raw_q;
    logic [1:0]  off_w;
    logic [2:0]  f3_w;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign widx = bus.ALU_resultM[ADDR_WIDTH+1:2];
    assign off  = bus.ALU_resultM[1:0];

    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        case (bus.funct3M)
            3'b000: begin
                be    = 4'b0001 << off;
                wdata = {4{bus.wr_dataM[7:0]}};
            end
            3'b001: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.wr_dataM[15:0]}};
            end
            3'b010: begin
                be    = 4'b1111;
                wdata = bus.wr_dataM;
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'h0;
            end
        endcase
    end

`ifdef MISALIGN_EXC_EN
    // Only real memory accesses (stores, or loads selecting memory data) can be misaligned.
    always_comb begin
        misal = 1'b0;
        if (bus.mem_wrM || (bus.result_srcM == 2'b01))
            misal = ((bus.funct3M[1:0] == 2'b01) && off[0]) ||
                    ((bus.funct3M == 3'b010) && (off != 2'b00));
    end
`else
    assign misal = 1'b0;
`endif

    assign we = bus.mem_wrM && !bus.stallW && !rst && !misal;

    // Storage is never reset; only the byte lanes selected by be are updated.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Raw read shares the W register's enable, so it returns the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr_q     <= 1'b0;
            result_src_q <= 2'b00;
            alu_q        <= 32'h0;
            pc4_q        <= RESET_PC4;
            rd_q         <= 5'd0;
            misalign_q   <= 1'b0;
            raw_q        <= 32'h0;
            off_w        <= 2'b00;
            f3_w         <= 3'b000;
        end else if (!bus.stallW) begin
            alu_q <= bus.ALU_resultM;
            pc4_q <= bus.PCp4M;
            raw_q <= mem[widx];
            off_w <= off;
            f3_w  <= bus.funct3M;
            if (bus.flushW) begin
                reg_wr_q     <= 1'b0;
                result_src_q <= 2'b00;
                rd_q         <= 5'd0;
                misalign_q   <= 1'b0;
            end else begin
                reg_wr_q     <= bus.reg_wrM && !misal;
                result_src_q <= bus.result_srcM;
                rd_q         <= bus.rdM;
                misalign_q   <= misal;
            end
        end
    end

    always_comb begin
        case (off_w)
            2'b00:   byte_sel = raw_q[7:0];
            2'b01:   byte_sel = raw_q[15:8];
            2'b10:   byte_sel = raw_q[23:16];
            default: byte_sel = raw_q[31:24];
        endcase
        half_sel = off_w[1] ? raw_q[31:16] : raw_q[15:0];
        case (f3_w)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            3'b010:  load_data = raw_q;
            default: load_data = 32'h0;
        endcase
    end

    assign bus.reg_wrW     = reg_wr_q;
    assign bus.result_srcW = result_src_q;
    assign bus.ALU_resultW = alu_q;
    assign bus.rd_dataW    = load_data;
    assign bus.PCp4W       = pc4_q;
    assign bus.rdW         = rd_q;
    assign bus.misalignW   = misalign_q;
endmodule

// File: tb/tb_mem_stage_bytes.sv
// Randomised and directed bench for mem_stage_bytes against a byte-addressed reference memory.
module tb_mem_stage_bytes;
    localparam int          AW    = 8;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] RPC   = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;

    mem_stage_bytes_if bus ();

    mem_stage_bytes #(.ADDR_WIDTH(AW), .RESET_PC4(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: flat byte memory plus expected W-side values.
    logic [7:0]  mref [4*DEPTH];
    bit          winit [DEPTH];
    logic        e_reg_wr;
    logic [1:0]  e_rs;
    logic [31:0] e_alu, e_rd_data, e_pc;
    logic [4:0]  e_rd;
    logic        e_mis;
    bit          e_rd_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [AW+1:0] a);
        logic [AW+1:0] ah, aw;
        ah = {a[AW+1:1], 1'b0};
        aw = {a[AW+1:2], 2'b00};
        case (f3)
            3'd0:    return {{24{mref[a][7]}}, mref[a]};
            3'd4:    return {24'h0, mref[a]};
            3'd1:    return {{16{mref[ah+1][7]}}, mref[ah+1], mref[ah]};
            3'd5:    return {16'h0, mref[ah+1], mref[ah]};
            3'd2:    return {mref[aw+3], mref[aw+2], mref[aw+1], mref[aw]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [AW+1:0] a, ah, aw;
        logic [2:0]    f3;
        logic [31:0]   wd;
        logic          mis;
        a   = bus.ALU_resultM[AW+1:0];
        ah  = {a[AW+1:1], 1'b0};
        aw  = {a[AW+1:2], 2'b00};
        f3  = bus.funct3M;
        wd  = bus.wr_dataM;
        mis = 1'b0;
`ifdef MISALIGN_EXC_EN
        if (bus.mem_wrM || bus.result_srcM == 2'b01)
            mis = (f3[1:0] == 2'b01 && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
`endif
        if (rst) begin
            e_reg_wr = 0; e_rs = 0; e_alu = 0; e_pc = RPC; e_rd = 0; e_mis = 0;
            e_rd_data = 0; e_rd_ok = 1;
        end else if (!bus.stallW) begin
            e_alu     = bus.ALU_resultM;
            e_pc      = bus.PCp4M;
            e_rd_ok   = winit[a[AW+1:2]] || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            e_rd_data = load_val(f3, a);
            if (bus.flushW) begin
                e_reg_wr = 0; e_rs = 0; e_rd = 0; e_mis = 0;
            end else begin
                e_reg_wr = bus.reg_wrM && !mis;
                e_rs     = bus.result_srcM;
                e_rd     = bus.rdM;
                e_mis    = mis;
            end
            if (bus.mem_wrM && !mis) begin
                case (f3)
                    3'd0: mref[a] = wd[7:0];
                    3'd1: begin mref[ah] = wd[7:0]; mref[ah+1] = wd[15:8]; end
                    3'd2: begin
                        mref[aw] = wd[7:0];   mref[aw+1] = wd[15:8];
                        mref[aw+2] = wd[23:16]; mref[aw+3] = wd[31:24];
                        winit[a[AW+1:2]] = 1;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        check("reg_wrW", bus.reg_wrW, e_reg_wr);
        check("result_srcW", bus.result_srcW, e_rs);
        check("ALU_resultW", bus.ALU_resultW, e_alu);
        check("PCp4W", bus.PCp4W, e_pc);
        check("rdW", bus.rdW, e_rd);
        check("misalignW", bus.misalignW, e_mis);
        if (e_rd_ok) check("rd_dataW", bus.rd_dataW, e_rd_data);
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic rw,
                         input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] rd);
        rst             = r;
        bus.stallW      = s;
        bus.flushW      = f;
        bus.reg_wrM     = rw;
        bus.result_srcM = rs;
        bus.mem_wrM     = mw;
        bus.funct3M     = f3;
        bus.ALU_resultM = alu;
        bus.wr_dataM    = wd;
        bus.PCp4M       = pc;
        bus.rdM         = rd;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic mem_op(input logic mw, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] wd);
        drive(0, 0, 0, !mw, 2'b01, mw, f3, alu, wd, $urandom, 5'($urandom));
    endtask

    initial begin
        drive(1, 0, 0, 1, 2'b11, 0, 3'd2, 32'hFFFF_FFFF, 0, 32'h1234, 5'd7);
        drive(1, 0, 0, 1, 2'b11, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h1234, 5'd7);
        check("reset_pc", bus.PCp4W, RPC);
        check("reset_rd_data", bus.rd_dataW, 32'h0);

        for (int i = 0; i < DEPTH; i++) mem_op(1, 3'd2, i * 4, $urandom);

        mem_op(1, 3'd2, 32'h10, 32'h8899_AABB);
        for (int k = 0; k < 4; k++) begin
            mem_op(0, 3'd0, 32'h10 + k, 0);
            if (k == 0) check("lb_off0", bus.rd_dataW, 32'hFFFF_FFBB);
            if (k == 1) check("lb_off1", bus.rd_dataW, 32'hFFFF_FFAA);
        end
        mem_op(0, 3'd4, 32'h13, 0);
        check("lbu_off3", bus.rd_dataW, 32'h0000_0088);

        mem_op(1, 3'd2, 32'h20, 32'h0);
        mem_op(1, 3'd1, 32'h22, 32'h5A5A_8001);
        mem_op(0, 3'd2, 32'h20, 0);
        check("lw_after_sh", bus.rd_dataW, 32'h8001_0000);
        mem_op(0, 3'd1, 32'h22, 0);
        check("lh", bus.rd_dataW, 32'hFFFF_8001);
        mem_op(0, 3'd5, 32'h22, 0);
        check("lhu", bus.rd_dataW, 32'h0000_8001);

        mem_op(1, 3'd2, 32'h4, 32'h1234_5600);
        repeat (3) drive(0, 1, 0, 1, 2'b01, 1, 3'd0, 32'h4, 32'h0000_00FF, $urandom, 5'd9);
        drive(0, 0, 0, 0, 2'b01, 1, 3'd0, 32'h4, 32'h0000_00FF, 32'h44, 5'd9);
        mem_op(0, 3'd2, 32'h4, 0);
        check("sb_after_stall", bus.rd_dataW, 32'h1234_56FF);

        drive(0, 0, 1, 1, 2'b01, 0, 3'd2, 32'h4, 0, 32'h48, 5'd5);
        check("flush_reg_wr", bus.reg_wrW, 32'h0);
        check("flush_rd", bus.rdW, 32'h0);
        drive(1, 0, 0, 1, 2'b01, 1, 3'd2, 32'h4, 32'hFFFF_FFFF, 32'h4C, 5'd5);
        check("rst_pc", bus.PCp4W, RPC);
        mem_op(0, 3'd2, 32'h4, 0);
        check("mem_kept_over_rst", bus.rd_dataW, 32'h1234_56FF);

        mem_op(1, 3'd2, 32'h8, 32'h5555);
        mem_op(1, 3'd2, 32'h8, 32'h1234);
        check("read_first", bus.rd_dataW, 32'h0000_5555);
        mem_op(0, 3'd2, 32'h8 + 4 * DEPTH, 0);
        check("alias_read", bus.rd_dataW, 32'h0000_1234);

        mem_op(1, 3'd2, 32'h0, 32'h1111_2222);
        mem_op(1, 3'd2, 32'h2, 32'hCAFE_F00D);
`ifdef MISALIGN_EXC_EN
        check("mis_flag", bus.misalignW, 32'h1);
        mem_op(0, 3'd2, 32'h0, 0);
        check("mis_no_write", bus.rd_dataW, 32'h1111_2222);
`else
        check("mis_flag", bus.misalignW, 32'h0);
        mem_op(0, 3'd2, 32'h0, 0);
        check("mis_aligned_down", bus.rd_dataW, 32'hCAFE_F00D);
`endif

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(99) == 0, $urandom_range(99) < 20, $urandom_range(99) < 15,
                  1'($urandom), 2'($urandom), $urandom_range(99) < 40, 3'($urandom),
                  $urandom, $urandom, $urandom, 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
